// File: rtl/fft_twiddle_sequencer_if.sv
// Control, twiddle-ROM and twiddle-stream signals of fft_twiddle_sequencer.
// master = sequencer side, slave = controller / ROM / butterfly datapath side.
interface fft_twiddle_sequencer_if #(
  parameter int FFT_TWIDDLE_WIDTH = 16
);
  logic                           start_i;
  logic [3:0]                     fft_len_log2_i;
  logic                           abort_i;
  logic                           busy_o;
  logic                           done_o;
  logic                           cfg_err_o;
  logic [15:0]                    rom_addr_o;
  logic                           rom_addr_valid_o;
  logic [2*FFT_TWIDDLE_WIDTH-1:0] rom_data_i;
  logic                           rom_data_valid_i;
  logic [2*FFT_TWIDDLE_WIDTH-1:0] tw_data_o;
  logic                           tw_valid_o;
  logic                           tw_ready_i;
  logic [3:0]                     tw_stage_o;
  logic                           tw_last_o;
  logic [31:0]                    stall_cycles_o;

  modport master (
    input  start_i, fft_len_log2_i, abort_i, rom_data_i, rom_data_valid_i, tw_ready_i,
    output busy_o, done_o, cfg_err_o, rom_addr_o, rom_addr_valid_o,
           tw_data_o, tw_valid_o, tw_stage_o, tw_last_o, stall_cycles_o
  );

  modport slave (
    output start_i, fft_len_log2_i, abort_i, rom_data_i, rom_data_valid_i, tw_ready_i,
    input  busy_o, done_o, cfg_err_o, rom_addr_o, rom_addr_valid_o,
           tw_data_o, tw_valid_o, tw_stage_o, tw_last_o, stall_cycles_o
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Twiddle read sequencer for an in-place radix-2 DIT FFT of length 2^L.
// Walks stage s / butterfly j, reads the max-length twiddle ROM, and streams
// the words through a 2-entry credit-managed FIFO to the butterfly datapath.
// Optional: define FFT_TWSEQ_PERF_EN to build the stall_cycles_o counter.
module fft_twiddle_sequencer #(
  parameter int FFT_MAX_FFT_LENGTH_LOG2 = 12,
  parameter int FFT_TWIDDLE_WIDTH       = 16
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  fft_twiddle_sequencer_if.master bus
);
  localparam int TW = 2 * FFT_TWIDDLE_WIDTH;
  localparam int EW = TW + 5;   // {last, stage[3:0], data}
  localparam logic [3:0] MAX_L = 4'(FFT_MAX_FFT_LENGTH_LOG2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    s_q, s_d;
  logic [15:0]   j_q, j_d;
  logic          infl_q, infl_d;
  logic [3:0]    infl_stage_q, infl_stage_d;
  logic          infl_last_q, infl_last_d;
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          pop, push, issue, last_iss, start_ok;
  logic [2:0]    used;
  logic [15:0]   half_m1, addr;
  logic [3:0]    shamt;

  // Issue bookkeeping: credits, ordering, and the twiddle index for (s, j)
  always_comb begin
    pop      = (cnt_q != 2'd0) && bus.tw_ready_i;
    push     = bus.rom_data_valid_i && infl_q;
    used     = {1'b0, cnt_q} + {2'b0, infl_q};
    issue    = (state_q == ST_ISSUE) && !bus.abort_i && (used < (3'd2 + {2'b0, pop}));
    half_m1  = (16'd1 << (len_q - 4'd1)) - 16'd1;
    last_iss = (s_q == len_q - 4'd1) && (j_q == half_m1);
    // k << (MAX-L) == (j mod 2^s) << (MAX-1-s)
    shamt    = MAX_L - 4'd1 - s_q;
    addr     = (j_q & ((16'd1 << s_q) - 16'd1)) << shamt;
    start_ok = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i &&
               (bus.fft_len_log2_i != 4'd0) && (bus.fft_len_log2_i <= MAX_L);
  end

  // FSM, counters, in-flight sideband and FIFO next state
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    s_d          = s_q;
    j_d          = j_q;
    infl_d       = issue;
    infl_stage_d = infl_stage_q;
    infl_last_d  = infl_last_q;
    mem_d        = mem_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    if (issue) begin
      infl_stage_d = s_q;
      infl_last_d  = last_iss;
    end
    if (push) begin
      mem_d[wr_q] = {infl_last_q, infl_stage_q, bus.rom_data_i};
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ISSUE;
          len_d   = bus.fft_len_log2_i;
          s_d     = 4'd0;
          j_d     = 16'd0;
        end else if (bus.start_i) begin
          cfg_err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          if (last_iss) begin
            state_d = ST_DRAIN;
          end else if (j_q == half_m1) begin
            j_d = 16'd0;
            s_d = s_q + 4'd1;
          end else begin
            j_d = j_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && bus.tw_last_o) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything: flush FIFO, drop in-flight response
    if (bus.abort_i) begin
      state_d   = ST_IDLE;
      infl_d    = 1'b0;
      cnt_d     = 2'd0;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      len_q        <= 4'd0;
      s_q          <= 4'd0;
      j_q          <= 16'd0;
      infl_q       <= 1'b0;
      infl_stage_q <= 4'd0;
      infl_last_q  <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      cnt_q        <= 2'd0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      s_q          <= s_d;
      j_q          <= j_d;
      infl_q       <= infl_d;
      infl_stage_q <= infl_stage_d;
      infl_last_q  <= infl_last_d;
      mem_q        <= mem_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.busy_o           = (state_q != ST_IDLE);
  assign bus.done_o           = done_q;
  assign bus.cfg_err_o        = cfg_err_q;
  assign bus.rom_addr_valid_o = issue;
  assign bus.rom_addr_o       = issue ? addr : 16'd0;
  assign bus.tw_valid_o       = (cnt_q != 2'd0);
  assign bus.tw_data_o        = mem_q[rd_q][TW-1:0];
  assign bus.tw_stage_o       = mem_q[rd_q][TW+3:TW];
  assign bus.tw_last_o        = mem_q[rd_q][TW+4];

`ifdef FFT_TWSEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of back-pressured cycles, cleared per accepted run
  always_comb begin
    stall_d = stall_q;
    if (start_ok)
      stall_d = 32'd0;
    else if (bus.tw_valid_o && !bus.tw_ready_i && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stall_q <= 32'd0;
    else            stall_q <= stall_d;
  end

  assign bus.stall_cycles_o = stall_q;
`else
  assign bus.stall_cycles_o = 32'd0;
`endif
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: table-driven L=3 check, model
// check for other lengths, plus cfg-error, abort, busy-start and reset cases.
module tb_fft_twiddle_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_twiddle_sequencer_if #(.FFT_TWIDDLE_WIDTH(16)) ifc();

  fft_twiddle_sequencer #(.FFT_MAX_FFT_LENGTH_LOG2(12), .FFT_TWIDDLE_WIDTH(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(ifc)
  );

  // ROM model: one-cycle latency, data = {addr, addr ^ A5A5}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc.rom_data_valid_i <= 1'b0;
      ifc.rom_data_i       <= '0;
    end else begin
      ifc.rom_data_valid_i <= ifc.rom_addr_valid_o;
      ifc.rom_data_i       <= {ifc.rom_addr_o, ifc.rom_addr_o ^ 16'hA5A5};
    end
  end

  typedef struct { logic [31:0] d; int st; bit ls; } tw_t;
  typedef struct { int addr; int stage; bit last; } vec_t;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state (written only by the monitor)
  logic clr = 1'b0;
  int   addr_q[$];
  tw_t  out_q[$];
  int   done_cnt, err_cnt, stall_cnt, outs, outs_viol, stab_viol;
  int   first_iss, first_tv, first_pop, last_pop, done_cyc;
  bit   prev_stall;
  tw_t  prev;

  always @(negedge clk) begin
    if (!rst_n || clr) begin
      addr_q.delete(); out_q.delete();
      done_cnt = 0; err_cnt = 0; stall_cnt = 0; outs = 0; outs_viol = 0; stab_viol = 0;
      first_iss = -1; first_tv = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
      prev_stall = 1'b0;
    end else begin
      if (ifc.rom_addr_valid_o) begin
        addr_q.push_back(int'(ifc.rom_addr_o));
        if (first_iss < 0) first_iss = cyc;
      end
      if (ifc.tw_valid_o && first_tv < 0) first_tv = cyc;
      if (prev_stall && (!ifc.tw_valid_o || ifc.tw_data_o != prev.d ||
                         int'(ifc.tw_stage_o) != prev.st || ifc.tw_last_o != prev.ls))
        stab_viol++;
      if (ifc.tw_valid_o && ifc.tw_ready_i) begin
        out_q.push_back('{ifc.tw_data_o, int'(ifc.tw_stage_o), ifc.tw_last_o});
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (ifc.tw_valid_o && !ifc.tw_ready_i) stall_cnt++;
      if (ifc.done_o) begin done_cnt++; done_cyc = cyc; end
      if (ifc.cfg_err_o) err_cnt++;
      outs = outs + int'(ifc.rom_addr_valid_o) - int'(ifc.tw_valid_o && ifc.tw_ready_i);
      if (outs > 2) outs_viol++;
      if (ifc.abort_i) outs = 0;
      prev_stall = ifc.tw_valid_o && !ifc.tw_ready_i && !ifc.abort_i;
      prev = '{ifc.tw_data_o, int'(ifc.tw_stage_o), ifc.tw_last_o};
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    tick();
  endtask

  function automatic int exp_addr(int l, int s, int j);
    int k;
    k = (j % (1 << s)) * (1 << (l - 1 - s));
    return k << (12 - l);
  endfunction

  int start_cyc;
  int sl = 0;

  // mode 0: ready held high; mode 1: toggling with random 3-cycle stalls.
  // poke: extra start pulses (L=5) while the run is busy.
  task automatic run(input int l, input int mode, input bit poke);
    bit fin = 1'b0;
    clear_mon();
    ifc.tw_ready_i = 1'b1;
    ifc.fft_len_log2_i = 4'(l);
    ifc.start_i = 1'b1;
    start_cyc = cyc;
    tick();
    ifc.start_i = 1'b0;
    for (int it = 0; it < 30000 && !fin; it++) begin
      if (mode == 1) begin
        if (sl > 0) begin ifc.tw_ready_i = 1'b0; sl--; end
        else if ($urandom_range(0, 5) == 0) begin ifc.tw_ready_i = 1'b0; sl = 2; end
        else ifc.tw_ready_i = !ifc.tw_ready_i;
      end else ifc.tw_ready_i = 1'b1;
      if (poke) begin
        if (it == 2 || it == 12) begin ifc.start_i = 1'b1; ifc.fft_len_log2_i = 4'd5; end
        else ifc.start_i = 1'b0;
      end
      @(negedge clk);
      if (ifc.done_o) fin = 1'b1;
      tick();
    end
    ifc.start_i = 1'b0;
    ifc.tw_ready_i = 1'b1;
    chk($sformatf("run_done_L%0d", l), fin, 1);
    repeat (3) tick();
  endtask

  task automatic check_run(input int l);
    int n, i, mis;
    logic [15:0] ea;
    n = l * (1 << (l - 1));
    i = 0; mis = 0;
    for (int s = 0; s < l; s++)
      for (int j = 0; j < (1 << (l - 1)); j++) begin
        ea = 16'(exp_addr(l, s, j));
        if (i < addr_q.size() && addr_q[i] != int'(ea)) mis++;
        if (i < out_q.size())
          if (out_q[i].d != {ea, ea ^ 16'hA5A5} || out_q[i].st != s || out_q[i].ls != (i == n - 1))
            mis++;
        i++;
      end
    chk($sformatf("addr_count_L%0d", l), addr_q.size(), n);
    chk($sformatf("pop_count_L%0d", l), out_q.size(), n);
    chk($sformatf("seq_mismatches_L%0d", l), mis, 0);
    chk($sformatf("done_count_L%0d", l), done_cnt, 1);
    chk($sformatf("outstanding_viol_L%0d", l), outs_viol, 0);
    chk($sformatf("hold_viol_L%0d", l), stab_viol, 0);
    chk($sformatf("busy_after_L%0d", l), ifc.busy_o, 0);
  endtask

  vec_t vec[12];

  task automatic check_tab(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (i < out_q.size()) begin
        chk($sformatf("%s_data%0d", tag, i), out_q[i].d[31:16], vec[i].addr);
        chk($sformatf("%s_sb%0d", tag, i), out_q[i].st * 2 + int'(out_q[i].ls),
            vec[i].stage * 2 + int'(vec[i].last));
      end else chk($sformatf("%s_missing%0d", tag, i), i, out_q.size());
      if (i < addr_q.size()) chk($sformatf("%s_addr%0d", tag, i), addr_q[i], vec[i].addr);
    end
  endtask

  initial begin
    int a[12] = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};
    for (int i = 0; i < 12; i++) vec[i] = '{a[i], i / 4, (i == 11)};

    ifc.start_i = 1'b0; ifc.fft_len_log2_i = 4'd0; ifc.abort_i = 1'b0; ifc.tw_ready_i = 1'b1;

    // Reset values
    #12;
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_done", ifc.done_o, 0);
    chk("rst_cfg_err", ifc.cfg_err_o, 0);
    chk("rst_addr_valid", ifc.rom_addr_valid_o, 0);
    chk("rst_addr", ifc.rom_addr_o, 0);
    chk("rst_tw_valid", ifc.tw_valid_o, 0);
    chk("rst_tw_last", ifc.tw_last_o, 0);
    chk("rst_stall", ifc.stall_cycles_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // L=3, ready high: table, latency, throughput, done timing
    run(3, 0, 1'b0);
    check_tab("l3");
    check_run(3);
    chk("l3_first_issue_lat", first_iss - start_cyc, 1);
    chk("l3_first_valid_lat", first_tv - start_cyc, 3);
    chk("l3_done_after_last", done_cyc - last_pop, 1);

    // L=3 with start pulses while busy: same sequence, single done
    run(3, 0, 1'b1);
    check_tab("l3poke");
    check_run(3);

    // Rejected lengths
    clear_mon();
    ifc.fft_len_log2_i = 4'd0; ifc.start_i = 1'b1; tick(); ifc.start_i = 1'b0;
    @(negedge clk);
    chk("cfg0_pulse", ifc.cfg_err_o, 1);
    chk("cfg0_busy", ifc.busy_o, 0);
    tick(); @(negedge clk);
    chk("cfg0_pulse_end", ifc.cfg_err_o, 0);
    ifc.fft_len_log2_i = 4'd13; ifc.start_i = 1'b1; tick(); ifc.start_i = 1'b0;
    @(negedge clk);
    chk("cfg13_pulse", ifc.cfg_err_o, 1);
    chk("cfg13_busy", ifc.busy_o, 0);
    repeat (3) tick();
    chk("cfg_err_count", err_cnt, 2);
    chk("cfg_no_strobes", addr_q.size(), 0);

    // L=4 with back-pressure
    run(4, 1, 1'b0);
    check_run(4);
`ifdef FFT_TWSEQ_PERF_EN
    chk("l4_stall_counter", ifc.stall_cycles_o, stall_cnt);
`else
    chk("l4_stall_tied0", ifc.stall_cycles_o, 0);
`endif

    // Abort on a cycle where a ROM response returns
    clear_mon();
    ifc.fft_len_log2_i = 4'd4; ifc.start_i = 1'b1; tick(); ifc.start_i = 1'b0;
    repeat (4) tick();
    chk("abort_resp_present", ifc.rom_data_valid_i, 1);
    ifc.abort_i = 1'b1; ifc.start_i = 1'b1;
    tick();
    ifc.abort_i = 1'b0; ifc.start_i = 1'b0;
    @(negedge clk);
    chk("abort_tw_valid", ifc.tw_valid_o, 0);
    chk("abort_busy", ifc.busy_o, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("abort_still_idle", ifc.busy_o, 0);
    chk("abort_no_done", done_cnt, 0);
    run(2, 0, 1'b0);
    check_run(2);
    if (addr_q.size() == 4) begin
      chk("l2_addr1", addr_q[1], 0);
      chk("l2_addr3", addr_q[3], 1024);
    end else chk("l2_addr_size", addr_q.size(), 4);

    // L=12 full throughput
    run(12, 0, 1'b0);
    check_run(12);
    chk("l12_first_pop_lat", first_pop - start_cyc, 3);
    chk("l12_pop_span", last_pop - first_pop, 24575);

    // Async reset mid-run acts immediately
    ifc.fft_len_log2_i = 4'd3; ifc.start_i = 1'b1; tick(); ifc.start_i = 1'b0;
    repeat (3) tick();
    chk("arst_pre_busy", ifc.busy_o, 1);
    rst_n = 1'b0; #1;
    chk("arst_busy", ifc.busy_o, 0);
    chk("arst_tw_valid", ifc.tw_valid_o, 0);
    chk("arst_addr_valid", ifc.rom_addr_valid_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
